// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: default widths and copy-engine state encodings.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 8;
    localparam int unsigned MEM_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } copy_state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy engine: on start, copies len bytes from src to dst through the single
// memory port (one read cycle, one write cycle per byte) and accumulates a byte checksum.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum
);

    copy_state_e       state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] data_reg;

    // Write data is the byte captured in READ; only sampled by memory while mem_we is high.
    assign mem_wdata = data_reg;

    // Transfer FSM; memory-port outputs are registered alongside the state so that each
    // state's port values are already in place for the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
            sum      <= '0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        src_ptr <= src;
                        dst_ptr <= dst;
                        count   <= len;
                        sum     <= '0;
                        if (len != '0) begin
                            state    <= S_READ;
                            busy     <= 1'b1;
                            mem_addr <= src;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    data_reg <= mem_rdata;
                    sum      <= sum + mem_rdata;
                    state    <= S_WRITE;
                    mem_addr <= dst_ptr;
                    mem_we   <= 1'b1;
                end
                S_WRITE: begin
                    src_ptr <= src_ptr + ADDR_W'(1);
                    dst_ptr <= dst_ptr + ADDR_W'(1);
                    count   <= count - ADDR_W'(1);
                    mem_we  <= 1'b0;
                    if (count == ADDR_W'(1)) begin
                        state    <= S_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        state    <= S_READ;
                        mem_addr <= src_ptr + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural 256x8 memory.
module tb_mem_copy_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic [7:0] sum;

    // Memory model: combinational read, synchronous write; bench preload port used when idle.
    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_wdata;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_addr] <= tb_wdata;
    end

    mem_copy_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] addr_log [16];
    logic       we_log   [16];
    logic       busy_log [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_addr  = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Drive start for exactly one edge (the accept edge), release just after it.
    task automatic do_start(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // lat = number of edges after the accept edge until the edge that samples done high.
    task automatic wait_done(input bit repulse, output int lat, output int we_cnt);
        bit seen;
        seen   = 1'b0;
        lat    = 0;
        we_cnt = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (c < 16) begin
                addr_log[c] = mem_addr;
                we_log[c]   = mem_we;
                busy_log[c] = busy;
            end
            if (mem_we) we_cnt++;
            if (repulse && c == 3) begin
                start = 1'b1;
                src   = 8'h00;
                dst   = 8'h90;
                len   = 8'd2;
            end
            if (repulse && c == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int we_cnt;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        src      = '0;
        dst      = '0;
        len      = '0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_we",   32'(mem_we),   32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        check("rst_busy", 32'(busy),     32'h0);
        check("rst_done", 32'(done),     32'h0);
        check("rst_sum",  32'(sum),      32'h0);
        rst = 1'b0;

        // Basic 4-byte copy
        preload(8'h10, 8'h01);
        preload(8'h11, 8'h02);
        preload(8'h12, 8'h03);
        preload(8'h13, 8'h04);
        do_start(8'h10, 8'h80, 8'd4);
        wait_done(1'b0, lat, we_cnt);
        check("basic_lat", 32'(lat), 32'd9);
        check("basic_sum", 32'(sum), 32'h0A);
        check("basic_we_cnt", 32'(we_cnt), 32'd4);
        check("basic_rd0_addr", 32'(addr_log[1]), 32'h10);
        check("basic_rd0_we", 32'(we_log[1]), 32'h0);
        check("basic_rd0_busy", 32'(busy_log[1]), 32'h1);
        check("basic_wr0_addr", 32'(addr_log[2]), 32'h80);
        check("basic_wr0_we", 32'(we_log[2]), 32'h1);
        check("basic_rd1_addr", 32'(addr_log[3]), 32'h11);
        check("basic_done_busy", 32'(busy_log[9]), 32'h0);
        check("basic_done_addr", 32'(addr_log[9]), 32'h0);
        for (int i = 0; i < 4; i++)
            check("basic_mem", 32'(mem[8'h80 + i]), 32'(i + 1));
        @(negedge clk);
        check("basic_done_1cyc", 32'(done), 32'h0);
        check("basic_sum_hold", 32'(sum), 32'h0A);

        // Zero length
        do_start(8'h10, 8'h50, 8'd0);
        wait_done(1'b0, lat, we_cnt);
        check("zero_lat", 32'(lat), 32'd1);
        check("zero_we_cnt", 32'(we_cnt), 32'd0);
        check("zero_sum", 32'(sum), 32'h0);
        check("zero_busy", 32'(busy_log[1]), 32'h0);

        // Source wrap-around
        preload(8'hFE, 8'hAA);
        preload(8'hFF, 8'hBB);
        preload(8'h00, 8'hCC);
        do_start(8'hFE, 8'h40, 8'd3);
        wait_done(1'b0, lat, we_cnt);
        check("wrap_lat", 32'(lat), 32'd7);
        check("wrap_sum", 32'(sum), 32'h31);
        check("wrap_rd2_addr", 32'(addr_log[5]), 32'h00);
        check("wrap_mem0", 32'(mem[8'h40]), 32'hAA);
        check("wrap_mem1", 32'(mem[8'h41]), 32'hBB);
        check("wrap_mem2", 32'(mem[8'h42]), 32'hCC);

        // Start re-pulsed while busy is ignored
        preload(8'h90, 8'h77);
        do_start(8'h10, 8'h60, 8'd4);
        wait_done(1'b1, lat, we_cnt);
        check("repulse_lat", 32'(lat), 32'd9);
        check("repulse_sum", 32'(sum), 32'h0A);
        check("repulse_untouched", 32'(mem[8'h90]), 32'h77);
        for (int i = 0; i < 4; i++)
            check("repulse_mem", 32'(mem[8'h60 + i]), 32'(i + 1));
        @(negedge clk);
        check("repulse_not_queued", 32'(busy), 32'h0);

        // Overlapping ascending copy re-reads written bytes
        preload(8'h20, 8'h55);
        preload(8'h21, 8'h11);
        preload(8'h22, 8'h11);
        preload(8'h23, 8'h11);
        do_start(8'h20, 8'h21, 8'd3);
        wait_done(1'b0, lat, we_cnt);
        check("overlap_sum", 32'(sum), 32'hFF);
        for (int i = 1; i < 4; i++)
            check("overlap_mem", 32'(mem[8'h20 + i]), 32'h55);

        // Reset during the write of byte 1
        for (int i = 0; i < 4; i++) preload(8'hA0 + 8'(i), 8'hEE);
        do_start(8'h10, 8'hA0, 8'd4);
        repeat (4) @(negedge clk);
        check("abort_pre_we", 32'(mem_we), 32'h1);
        check("abort_pre_addr", 32'(mem_addr), 32'hA1);
        rst = 1'b1;
        #1;
        check("abort_we", 32'(mem_we), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_sum", 32'(sum), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_mem0", 32'(mem[8'hA0]), 32'h01);
        check("abort_mem1", 32'(mem[8'hA1]), 32'hEE);
        check("abort_mem2", 32'(mem[8'hA2]), 32'hEE);

        // Normal operation after abort
        do_start(8'h10, 8'hB0, 8'd2);
        wait_done(1'b0, lat, we_cnt);
        check("post_lat", 32'(lat), 32'd5);
        check("post_sum", 32'(sum), 32'h03);
        check("post_mem0", 32'(mem[8'hB0]), 32'h01);
        check("post_mem1", 32'(mem[8'hB1]), 32'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
